// File: rtl/game_flow_controller.sv
// Match sequencer for Connect4: accepts column drops, writes the board store,
// runs the win-check handshake, alternates turns and decides win or tie.
module game_flow_controller #(
    parameter int COLS   = 7,
    parameter int ROWS   = 6,
    parameter int MOVE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              move_valid,
    input  logic [2:0]        move_col,
    output logic              move_ready,
    output logic              move_reject,
    output logic              cell_we,
    output logic [2:0]        cell_col,
    output logic [2:0]        cell_row,
    output logic [1:0]        cell_player,
    output logic              chk_req,
    input  logic              chk_ack,
    input  logic              chk_win,
    output logic [1:0]        state,
    output logic [1:0]        game_status,
    output logic [MOVE_W-1:0] moves_made
);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    localparam logic [1:0] ST_PLAYING = 2'b00;
    localparam logic [1:0] ST_TIE     = 2'b11;

    localparam int                H_W    = $clog2(ROWS + 1);
    localparam logic [H_W-1:0]    ROWS_H = H_W'(ROWS);
    localparam logic [H_W-1:0]    H_ONE  = H_W'(1);
    localparam logic [H_W-1:0]    H_ZERO = H_W'(0);
    localparam logic [3:0]        COLS_C = 4'(COLS);
    localparam logic [MOVE_W-1:0] CELLS  = MOVE_W'(COLS * ROWS);
    localparam logic [MOVE_W-1:0] M_ONE  = MOVE_W'(1);
    localparam logic [MOVE_W-1:0] M_ZERO = MOVE_W'(0);

    // mover 0 = P1, 1 = P2; the same code is used for disc owner and win status
    function automatic logic [1:0] player_code(input logic m);
        return m ? 2'b10 : 2'b01;
    endfunction

    logic [1:0]        fsm_q, fsm_d;
    logic              mover_q, mover_d;
    logic [H_W-1:0]    height_q [COLS];
    logic [H_W-1:0]    height_d [COLS];
    logic [MOVE_W-1:0] moves_made_q, moves_made_d;
    logic [1:0]        game_status_q, game_status_d;
    logic [1:0]        state_q, state_d;
    logic              move_ready_q, move_ready_d;
    logic              move_reject_q, move_reject_d;
    logic              cell_we_q, cell_we_d;
    logic [2:0]        cell_col_q, cell_col_d;
    logic [2:0]        cell_row_q, cell_row_d;
    logic [1:0]        cell_player_q, cell_player_d;
    logic              chk_req_q, chk_req_d;

    logic [H_W-1:0]    sel_height_s;
    logic              col_ok_s;
    logic              accept_s;

    // Height of the requested column; out-of-range columns read as empty
    always_comb begin
        sel_height_s = H_ZERO;
        for (int c = 0; c < COLS; c++) begin
            if (move_col == 3'(c)) begin
                sel_height_s = height_q[c];
            end else begin
                sel_height_s = sel_height_s;
            end
        end
        col_ok_s = ({1'b0, move_col} < COLS_C);
        accept_s = (fsm_q == S_TURN) && move_valid && col_ok_s && (sel_height_s < ROWS_H);
    end

    // Next-state logic for the match sequencer and all registered outputs
    always_comb begin
        fsm_d         = fsm_q;
        mover_d       = mover_q;
        height_d      = height_q;
        moves_made_d  = moves_made_q;
        game_status_d = game_status_q;
        move_reject_d = 1'b0;
        cell_we_d     = 1'b0;
        cell_col_d    = cell_col_q;
        cell_row_d    = cell_row_q;
        cell_player_d = cell_player_q;
        chk_req_d     = chk_req_q;

        case (fsm_q)
            S_INIT: begin
                if (start) begin
                    fsm_d         = S_TURN;
                    mover_d       = 1'b0;
                    moves_made_d  = M_ZERO;
                    game_status_d = ST_PLAYING;
                    for (int c = 0; c < COLS; c++) height_d[c] = H_ZERO;
                end else begin
                    fsm_d = S_INIT;
                end
            end
            S_TURN: begin
                if (accept_s) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (move_col == 3'(c)) begin
                            height_d[c] = height_q[c] + H_ONE;
                        end else begin
                            height_d[c] = height_q[c];
                        end
                    end
                    moves_made_d  = moves_made_q + M_ONE;
                    fsm_d         = S_CHECK;
                    cell_we_d     = 1'b1;
                    cell_col_d    = move_col;
                    cell_row_d    = 3'(sel_height_s);
                    cell_player_d = player_code(mover_q);
                    chk_req_d     = 1'b1;
                end else if (move_valid) begin
                    move_reject_d = 1'b1;
                end else begin
                    fsm_d = S_TURN;
                end
            end
            S_CHECK: begin
                if (chk_ack && chk_req_q) begin
                    chk_req_d = 1'b0;
                    if (chk_win) begin
                        fsm_d         = S_END;
                        game_status_d = player_code(mover_q);
                    end else if (moves_made_q == CELLS) begin
                        fsm_d         = S_END;
                        game_status_d = ST_TIE;
                    end else begin
                        fsm_d   = S_TURN;
                        mover_d = ~mover_q;
                    end
                end else begin
                    fsm_d = S_CHECK;
                end
            end
            S_END: begin
                if (start) begin
                    fsm_d         = S_INIT;
                    game_status_d = ST_PLAYING;
                    moves_made_d  = M_ZERO;
                    for (int c = 0; c < COLS; c++) height_d[c] = H_ZERO;
                end else begin
                    fsm_d = S_END;
                end
            end
            default: begin
                fsm_d     = S_INIT;
                chk_req_d = 1'b0;
            end
        endcase

        case (fsm_d)
            S_INIT:          state_d = 2'b00;
            S_TURN, S_CHECK: state_d = player_code(mover_d);
            S_END:           state_d = 2'b11;
            default:         state_d = 2'b00;
        endcase
        move_ready_d = (fsm_d == S_TURN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= S_INIT;
            mover_q       <= 1'b0;
            for (int c = 0; c < COLS; c++) height_q[c] <= H_ZERO;
            moves_made_q  <= M_ZERO;
            game_status_q <= ST_PLAYING;
            state_q       <= 2'b00;
            move_ready_q  <= 1'b0;
            move_reject_q <= 1'b0;
            cell_we_q     <= 1'b0;
            cell_col_q    <= 3'd0;
            cell_row_q    <= 3'd0;
            cell_player_q <= 2'b00;
            chk_req_q     <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            mover_q       <= mover_d;
            height_q      <= height_d;
            moves_made_q  <= moves_made_d;
            game_status_q <= game_status_d;
            state_q       <= state_d;
            move_ready_q  <= move_ready_d;
            move_reject_q <= move_reject_d;
            cell_we_q     <= cell_we_d;
            cell_col_q    <= cell_col_d;
            cell_row_q    <= cell_row_d;
            cell_player_q <= cell_player_d;
            chk_req_q     <= chk_req_d;
        end
    end

    assign move_ready  = move_ready_q;
    assign move_reject = move_reject_q;
    assign cell_we     = cell_we_q;
    assign cell_col    = cell_col_q;
    assign cell_row    = cell_row_q;
    assign cell_player = cell_player_q;
    assign chk_req     = chk_req_q;
    assign state       = state_q;
    assign game_status = game_status_q;
    assign moves_made  = moves_made_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scenario bench for game_flow_controller: board writes are scoreboarded,
// FSM outputs are compared against a small reference model of the match.
module tb_game_flow_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [2:0] move_col = 3'd0;
    logic       move_ready, move_reject, cell_we, chk_req;
    logic [2:0] cell_col, cell_row;
    logic [1:0] cell_player, state, game_status;
    logic       chk_ack = 1'b0;
    logic       chk_win = 1'b0;
    logic [5:0] moves_made;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] e, o;

    int         m_height [7];
    int         m_moves;
    logic [1:0] m_player;
    logic [1:0] m_state;
    logic [1:0] m_status;
    logic       req_seen;

    game_flow_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .move_valid(move_valid), .move_col(move_col),
        .move_ready(move_ready), .move_reject(move_reject),
        .cell_we(cell_we), .cell_col(cell_col), .cell_row(cell_row),
        .cell_player(cell_player), .chk_req(chk_req),
        .chk_ack(chk_ack), .chk_win(chk_win),
        .state(state), .game_status(game_status), .moves_made(moves_made)
    );

    always #5 clk = ~clk;

    // Capture every board write (values of the cycle just ending)
    always @(posedge clk) begin
        if (cell_we === 1'b1) obs_q.push_back({cell_col, cell_row, cell_player});
    end

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic fresh_match();
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        start_pulse();
        for (int c = 0; c < 7; c++) m_height[c] = 0;
        m_moves  = 0;
        m_player = 2'b01;
        m_state  = 2'b01;
        m_status = 2'b00;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Legal drop followed by an ack after 'delay' extra cycles; updates the model
    task automatic do_move(input int col, input logic win, input int delay, output logic seen);
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'(col);
        exp_q.push_back({3'(col), 3'(m_height[col]), m_player});
        m_height[col]++;
        m_moves++;
        @(negedge clk);
        move_valid = 1'b0;
        seen = chk_req;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            seen = seen & chk_req;
        end
        chk_ack = 1'b1;
        chk_win = win;
        @(negedge clk);
        chk_ack = 1'b0;
        chk_win = 1'b0;
        if (win) begin
            m_state  = 2'b11;
            m_status = m_player;
        end else if (m_moves == 42) begin
            m_state  = 2'b11;
            m_status = 2'b11;
        end else begin
            m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
            m_state  = m_player;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({state, game_status, move_ready, move_reject, cell_we, chk_req} !== 8'b0000_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b", {state, game_status, move_ready, move_reject, cell_we, chk_req}, 8'b0);
        end
        total++;
        if ({moves_made, cell_col, cell_row, cell_player} !== 14'd0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {moves_made, cell_col, cell_row, cell_player});
        end
    endtask

    task automatic test_first_move();
        fresh_match();
        total++;
        if ({state, game_status, move_ready} !== 5'b01_00_1) begin
            bad++;
            $display("FAIL start_turn got=%b exp=%b", {state, game_status, move_ready}, 5'b01_00_1);
        end
        do_move(3, 1'b0, 0, req_seen);
        total++;
        if (req_seen !== 1'b1) begin
            bad++;
            $display("FAIL first_req got=%b exp=1", req_seen);
        end
        total++;
        if ({state, moves_made} !== {m_state, 6'(m_moves)} || m_state !== 2'b10) begin
            bad++;
            $display("FAIL first_turn got=%b/%0d exp=10/1", state, moves_made);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            total++;
            if (o !== e) begin bad++; $display("FAIL first_write got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_full_column();
        fresh_match();
        for (int i = 0; i < 6; i++) do_move(0, 1'b0, 0, req_seen);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            move_valid = 1'b1;
            move_col   = (k == 0) ? 3'd0 : 3'd7;
            @(negedge clk);
            move_valid = 1'b0;
            total++;
            if ({move_reject, cell_we, chk_req, move_ready, state} !== {4'b1001, m_state}) begin
                bad++;
                $display("FAIL reject_%0d got=%b exp=%b", k, {move_reject, cell_we, chk_req, move_ready, state}, {4'b1001, m_state});
            end
            @(negedge clk);
            total++;
            if ({move_reject, moves_made} !== {1'b0, 6'd6}) begin
                bad++;
                $display("FAIL reject_end_%0d got=%b/%0d exp=0/6", k, move_reject, moves_made);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            total++;
            if (o !== e) begin bad++; $display("FAIL column_write got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL column_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_check_wait();
        fresh_match();
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'd2;
        exp_q.push_back({3'd2, 3'd0, 2'b01});
        @(negedge clk);
        move_col = 3'd4;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({chk_req, state, move_ready} !== 4'b1_01_0) begin
                bad++;
                $display("FAIL wait_%0d got=%b exp=%b", i, {chk_req, state, move_ready}, 4'b1_01_0);
            end
            @(negedge clk);
        end
        move_valid = 1'b0;
        chk_ack = 1'b1;
        chk_win = 1'b1;
        @(negedge clk);
        chk_ack = 1'b0;
        chk_win = 1'b0;
        total++;
        if ({state, game_status, move_ready, chk_req, moves_made} !== {2'b11, 2'b01, 2'b00, 6'd1}) begin
            bad++;
            $display("FAIL p1_win got=%b exp=%b", {state, game_status, move_ready, chk_req, moves_made}, {2'b11, 2'b01, 2'b00, 6'd1});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            total++;
            if (o !== e) begin bad++; $display("FAIL wait_write got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL wait_extra got=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_fill();
        for (int pass = 0; pass < 2; pass++) begin
            fresh_match();
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++)
                    do_move(c, (pass == 1 && c == 6 && r == 5), 0, req_seen);
            total++;
            if ({state, game_status, moves_made, move_ready} !== {m_state, m_status, 6'd42, 1'b0}) begin
                bad++;
                $display("FAIL fill_end_%0d got=%b/%b/%0d exp=%b/%b/42", pass, state, game_status, moves_made, m_state, m_status);
            end
            total++;
            if (game_status !== ((pass == 0) ? 2'b11 : 2'b10)) begin
                bad++;
                $display("FAIL fill_status_%0d got=%b", pass, game_status);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
                total++;
                if (o !== e) begin bad++; $display("FAIL fill_write got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_end_restart();
        start_pulse();
        total++;
        if ({state, game_status, moves_made, move_ready} !== 11'd0) begin
            bad++;
            $display("FAIL end_to_init got=%b/%b/%0d/%b exp=0", state, game_status, moves_made, move_ready);
        end
        start_pulse();
        total++;
        if ({state, move_ready} !== 3'b01_1) begin
            bad++;
            $display("FAIL init_to_turn got=%b exp=011", {state, move_ready});
        end
        start_pulse();
        total++;
        if ({state, move_ready, moves_made} !== {2'b01, 1'b1, 6'd0}) begin
            bad++;
            $display("FAIL start_in_turn got=%b/%b/%0d exp=01/1/0", state, move_ready, moves_made);
        end
    endtask

    task automatic test_reset_in_check();
        fresh_match();
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'd5;
        @(negedge clk);
        move_valid = 1'b0;
        total++;
        if (chk_req !== 1'b1) begin bad++; $display("FAIL pre_reset_req got=%b exp=1", chk_req); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({state, chk_req, move_ready} !== 4'b0) begin
            bad++;
            $display("FAIL async_reset got=%b exp=0000", {state, chk_req, move_ready});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        chk_ack = 1'b1;
        chk_win = 1'b1;
        @(negedge clk);
        chk_ack = 1'b0;
        chk_win = 1'b0;
        @(negedge clk);
        total++;
        if ({state, game_status, chk_req, moves_made} !== 11'd0) begin
            bad++;
            $display("FAIL stale_ack got=%b/%b/%b/%0d exp=0", state, game_status, chk_req, moves_made);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_first_move();
        test_full_column();
        test_check_wait();
        test_fill();
        test_end_restart();
        test_reset_in_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level sequencer for one Connect4 match. Owns the 2-bit `state` and `game_status` buses consumed by the LED status display.
- Accepts column-drop requests from the input front end and tracks per-column fill heights.
- Writes accepted discs to the board store and runs a request/acknowledge handshake with the external win checker.
- Alternates turns and decides win or tie.

Parameters:
- COLS, 7, number of board columns (column index 0..COLS-1)
- ROWS, 6, number of board rows (row index 0 = bottom)
- MOVE_W, 6, width of move counter; must hold COLS*ROWS

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request: begin match / return from end screen
- move_valid  in  1  player drop request, qualified by move_ready
- move_col  in  3  requested column
- move_ready  out  1  high while a drop can be accepted
- move_reject  out  1  one-cycle pulse: request refused (bad or full column)
- cell_we  out  1  one-cycle board write strobe
- cell_col  out  3  column of written disc
- cell_row  out  3  row of written disc
- cell_player  out  2  01 = P1, 10 = P2
- chk_req  out  1  win-check request, held until acknowledged
- chk_ack  in  1  win-check done, sampled only while chk_req = 1
- chk_win  in  1  result, valid with chk_ack: last mover has four in a row
- state  out  2  00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME
- game_status  out  2  00 STILL_PLAYING, 01 P1_WINS, 10 P2_WINS, 11 TIE
- moves_made  out  MOVE_W  discs placed this match

Behaviour:

Reset:
- rst_n low asynchronously forces the following values; all outputs are registered:
  - state = GAME_INIT, game_status = STILL_PLAYING
  - all column heights = 0, moves_made = 0
  - move_ready, move_reject, cell_we, chk_req = 0
  - cell_col, cell_row, cell_player = 0
- Reset mid-match or mid-check abandons everything. A later chk_ack is ignored because chk_req is 0.

Internal FSM: INIT, TURN, CHECK, END.
- `state` output:
  - INIT -> 00
  - TURN/CHECK -> the current mover's encoding (01 or 10)
  - END -> 11
- Mover register: P1 or P2.

INIT:
- move_ready = 0.
- start = 1 -> TURN with mover = P1. Heights, moves_made and game_status are cleared on the same edge.

TURN:
- move_ready = 1.
- start is ignored.
- Edge with move_valid = 1, column index valid and not full (move_col < COLS, height[move_col] < ROWS):
  - Accept: height[move_col]++, moves_made++.
  - Go to CHECK.
  - In the next cycle: cell_we = 1 for exactly one cycle, with cell_col = move_col, cell_row = old height, cell_player = mover. chk_req rises in that same cycle.
- move_valid = 1 with move_col >= COLS or height = ROWS:
  - move_reject = 1 for the next cycle.
  - No other change; stay in TURN.

CHECK:
- move_ready = 0. move_valid and start are ignored.
- chk_req stays 1 until an edge with chk_ack = 1. chk_req drops on that edge.
- Decision on that edge:
  - chk_win = 1 -> END, game_status = mover's win code (01/10).
  - else moves_made = COLS*ROWS -> END, game_status = TIE.
  - else -> TURN with mover toggled.
- Win takes priority over tie on the final disc.
- Minimum accept-to-next-turn latency: 2 cycles (accept edge; chk_ack high in the cycle after).

END:
- move_ready = 0. game_status holds.
- start = 1 -> INIT. game_status becomes STILL_PLAYING; heights and moves_made are cleared.
- A second start is needed to begin a new match.

Other rules:
- chk_ack while chk_req = 0 is ignored.
- Height counters saturate at ROWS; moves_made never exceeds COLS*ROWS.

Test Plan:
1. Reset then start -> state 00 then 01, game_status 00, move_ready 1; drop col 3 -> next cycle cell_we = 1, col 3, row 0, player 01, chk_req 1; ack with win = 0 -> state 10, moves_made 1.
2. Six drops into col 0 (ack win = 0 each), then seventh drop into col 0 -> move_reject pulse, state unchanged, moves_made 6, no cell_we; move_col = 7 -> move_reject also pulses.
3. P1 moves; chk_ack held low 5 cycles -> chk_req stays 1, state 01, move_valid ignored; then ack with win = 1 -> state 11, game_status 01, move_ready 0.
4. Fill all 42 cells (ack win = 0) -> after 42nd ack state 11, game_status 11; repeat with win = 1 on the 42nd ack (P2 mover) -> game_status 10.
5. In END, start -> state 00, status 00, moves_made 0; start again -> 01; start pulsed during TURN -> no effect.
6. Assert rst_n low during CHECK -> immediate state 00, chk_req 0; later chk_ack -> no change.
